// File: rtl/di_reg_terminal_if.sv
// Register-terminal bus: transfer addressing, write/read strobes,
// handshake readies, read data and transfer status.
interface di_reg_terminal_if;
  logic [15:0] di_term_addr;
  logic [31:0] di_reg_addr;
  logic        di_write;
  logic [31:0] di_reg_datai;
  logic        di_write_rdy;
  logic        di_read_req;
  logic        di_read;
  logic        di_read_rdy;
  logic [31:0] di_reg_datao;
  logic [15:0] di_transfer_status;

  modport master (
    output di_term_addr, di_reg_addr, di_write, di_reg_datai, di_read_req, di_read,
    input  di_write_rdy, di_read_rdy, di_reg_datao, di_transfer_status
  );

  modport slave (
    input  di_term_addr, di_reg_addr, di_write, di_reg_datai, di_read_req, di_read,
    output di_write_rdy, di_read_rdy, di_reg_datao, di_transfer_status
  );
endinterface

// File: rtl/di_reg_terminal.sv
// Addressable register terminal: register 0 is a read-only ID, registers
// 1..NUM_REGS-1 are read/write. Reads complete after a fixed latency, writes
// hold the terminal busy for a fixed number of cycles, and a read request
// colliding with a write is deferred until the terminal is idle again.
module di_reg_terminal #(
  parameter logic [15:0] TERM_ADDR     = 16'h0010,
  parameter int          NUM_REGS      = 8,
  parameter int          REG_WIDTH     = 16,
  parameter int          READ_LATENCY  = 2,
  parameter int          WRITE_LATENCY = 1,
  parameter logic [15:0] ID_VALUE      = 16'hA55A
) (
  input  logic                          clk,
  input  logic                          reset_n,
  di_reg_terminal_if.slave              bus,
  output logic [NUM_REGS*REG_WIDTH-1:0] regs_flat,
  output logic                          reg_wr_stb,
  output logic [7:0]                    reg_wr_addr
);
  localparam int          IDX_W   = $clog2(NUM_REGS);
  localparam logic [31:0] NREGS32 = 32'(NUM_REGS);
  localparam logic [31:0] ID32    = {16'h0000, ID_VALUE};
  // Counters load latency-1 (write) / latency-2 (read) because the cycle
  // spent entering the state already counts toward the latency.
  localparam logic [3:0]  WR_LOAD = (WRITE_LATENCY > 0) ? 4'(WRITE_LATENCY - 1) : 4'd0;
  localparam logic [3:0]  RD_LOAD = (READ_LATENCY > 1) ? 4'(READ_LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_VALID, WR_BUSY} state_t;

  state_t               state, state_nx;
  logic [3:0]           cnt, cnt_nx;
  logic                 pend, pend_nx;
  logic [31:0]          pend_addr, pend_addr_nx;
  logic [31:0]          rd_addr, rd_addr_nx;
  logic [REG_WIDTH-1:0] regs [NUM_REGS];
  logic [31:0]          datao;
  logic [15:0]          status;

  logic                 sel, wr_rdy, wr_acc, wr_ovr, wr_in_range, wr_en;
  logic                 pend_go, rd_new, rd_start, rd_done;
  logic [31:0]          rd_start_addr, sample_addr, sample_val;
  logic [REG_WIDTH-1:0] wr_data;
  logic                 unused_bits;

  assign sel           = (bus.di_term_addr == TERM_ADDR);
  assign wr_rdy        = (state == IDLE) || (state == RD_VALID);
  assign wr_acc        = sel && bus.di_write && wr_rdy;
  assign wr_ovr        = sel && bus.di_write && !wr_rdy;
  // Full 32-bit compare so high address bits never alias onto a register.
  assign wr_in_range   = (bus.di_reg_addr < NREGS32);
  assign wr_en         = wr_acc && wr_in_range && (bus.di_reg_addr != 32'd0);
  assign wr_data       = bus.di_reg_datai[REG_WIDTH-1:0];
  // A deferred read wins over a fresh request once the terminal is idle.
  assign pend_go       = (state == IDLE) && pend && !wr_acc;
  assign rd_new        = sel && bus.di_read_req && wr_rdy && !wr_acc && !pend_go;
  assign rd_start      = rd_new || pend_go;
  assign rd_start_addr = pend_go ? pend_addr : bus.di_reg_addr;
  assign rd_done       = (rd_start && (READ_LATENCY == 1)) || ((state == RD_WAIT) && (cnt == 4'd0));
  assign sample_addr   = (state == RD_WAIT) ? rd_addr : rd_start_addr;
  assign unused_bits   = ^bus.di_reg_datai;

  assign bus.di_write_rdy       = wr_rdy;
  assign bus.di_read_rdy        = (state == RD_VALID);
  assign bus.di_reg_datao       = datao;
  assign bus.di_transfer_status = status;

  // Read data selection, forwarding a same-cycle write to the sampled register
  always_comb begin
    sample_val = 32'd0;
    if (sample_addr == 32'd0) begin
      sample_val = ID32;
    end else if (sample_addr < NREGS32) begin
      if (wr_en && (sample_addr == bus.di_reg_addr)) sample_val = 32'(wr_data);
      else                                           sample_val = 32'(regs[sample_addr[IDX_W-1:0]]);
    end
  end

  // Flatten the register file; slot 0 shows the fixed ID
  always_comb begin
    regs_flat = '0;
    regs_flat[REG_WIDTH-1:0] = ID32[REG_WIDTH-1:0];
    for (int k = 1; k < NUM_REGS; k++) regs_flat[k*REG_WIDTH +: REG_WIDTH] = regs[k];
  end

  // Next-state logic: write beats read, latency counters stop at zero
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    pend_nx      = pend;
    pend_addr_nx = pend_addr;
    rd_addr_nx   = rd_addr;
    case (state)
      IDLE, RD_VALID: begin
        if (wr_acc) begin
          if (WRITE_LATENCY == 0) begin
            state_nx = IDLE;
          end else begin
            state_nx = WR_BUSY;
            cnt_nx   = WR_LOAD;
          end
          if (bus.di_read_req) begin
            pend_nx      = 1'b1;
            pend_addr_nx = bus.di_reg_addr;
          end
        end else if (rd_start) begin
          rd_addr_nx = rd_start_addr;
          pend_nx    = 1'b0;
          if (READ_LATENCY == 1) begin
            state_nx = RD_VALID;
          end else begin
            state_nx = RD_WAIT;
            cnt_nx   = RD_LOAD;
          end
        end else if ((state == RD_VALID) && sel && bus.di_read) begin
          state_nx = IDLE;
        end
      end
      RD_WAIT: begin
        if (cnt == 4'd0) state_nx = RD_VALID;
        else             cnt_nx   = cnt - 4'd1;
      end
      WR_BUSY: begin
        if (cnt == 4'd0) state_nx = IDLE;
        else             cnt_nx   = cnt - 4'd1;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Control state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      pend      <= 1'b0;
      pend_addr <= 32'd0;
      rd_addr   <= 32'd0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      pend      <= pend_nx;
      pend_addr <= pend_addr_nx;
      rd_addr   <= rd_addr_nx;
    end
  end

  // Register file update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else if (wr_en) begin
      regs[bus.di_reg_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  // Registered outputs: write strobe, read data, transfer status
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_wr_stb  <= 1'b0;
      reg_wr_addr <= 8'd0;
      datao       <= 32'd0;
      status      <= 16'd0;
    end else begin
      reg_wr_stb <= wr_en;
      if (wr_en)   reg_wr_addr <= bus.di_reg_addr[7:0];
      if (rd_done) datao       <= sample_val;
      if (wr_acc)
        status <= !wr_in_range ? 16'h0001 : (bus.di_reg_addr == 32'd0) ? 16'h0002 : 16'h0000;
      else if (wr_ovr)
        status <= 16'h0004;
      else if (rd_start)
        status <= (rd_start_addr < NREGS32) ? 16'h0000 : 16'h0001;
    end
  end
endmodule

// File: tb/tb_di_reg_terminal.sv
// Bench for di_reg_terminal: timestamp-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_di_reg_terminal;
  localparam logic [15:0] T  = 16'h0010;
  localparam int          N  = 8;
  localparam int          W  = 16;
  localparam int          RL = 2;
  localparam int          WL = 1;
  localparam int          IW = $clog2(N);
  localparam logic [15:0] ID = 16'hA55A;

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [N*W-1:0] regs_flat;
  logic           reg_wr_stb;
  logic [7:0]     reg_wr_addr;

  di_reg_terminal_if bus();

  di_reg_terminal #(
    .TERM_ADDR(T), .NUM_REGS(N), .REG_WIDTH(W),
    .READ_LATENCY(RL), .WRITE_LATENCY(WL), .ID_VALUE(ID)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .regs_flat(regs_flat), .reg_wr_stb(reg_wr_stb), .reg_wr_addr(reg_wr_addr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle stamps for busy windows and read completion
  int          cyc = 0;
  logic [W-1:0] m_regs [N];
  int          busy_end = 0;
  bit          rd_out = 0;
  int          rd_start = 0;
  logic [31:0] rd_val = 0;
  bit          pend = 0;
  logic [31:0] pend_addr = 0;
  logic [31:0] m_datao = 0;
  logic [15:0] m_status = 0;
  bit          m_stb = 0;
  logic [7:0]  m_wr_addr = 0;

  function automatic logic [31:0] read_value(input logic [31:0] a);
    if (a == 32'd0) return {16'h0000, ID};
    if (a < N)      return 32'(m_regs[a[IW-1:0]]);
    return 32'd0;
  endfunction

  always @(posedge clk) begin : model
    bit          sel, rdy_now, in_valid, go;
    logic [31:0] a, sa;
    a  = bus.di_reg_addr;
    sa = 32'd0;
    go = 0;
    if (!reset_n) begin
      for (int k = 0; k < N; k++) m_regs[k] = '0;
      busy_end = 0; rd_out = 0; pend = 0; pend_addr = 0;
      m_datao = 0; m_status = 0; m_stb = 0; m_wr_addr = 0;
    end else begin
      sel      = (bus.di_term_addr == T);
      rdy_now  = (cyc >= busy_end) && !(rd_out && cyc < rd_start + RL);
      in_valid = rd_out && (cyc >= rd_start + RL);
      m_stb    = 0;
      if (sel && bus.di_write && rdy_now) begin
        if (a >= N)          m_status = 16'h0001;
        else if (a == 32'd0) m_status = 16'h0002;
        else begin
          m_regs[a[IW-1:0]] = bus.di_reg_datai[W-1:0];
          m_status  = 16'h0000;
          m_stb     = 1;
          m_wr_addr = a[7:0];
        end
        busy_end = cyc + 1 + WL;
        rd_out   = 0;
        if (bus.di_read_req) begin pend = 1; pend_addr = a; end
      end else if (sel && bus.di_write) begin
        m_status = 16'h0004;
      end else if (rdy_now && !in_valid && pend) begin
        go = 1; sa = pend_addr; pend = 0;
      end else if (rdy_now && sel && bus.di_read_req) begin
        go = 1; sa = a;
      end else if (in_valid && sel && bus.di_read) begin
        rd_out = 0;
      end
      if (go) begin
        rd_out   = 1;
        rd_start = cyc;
        rd_val   = read_value(sa);
        m_status = (sa < N) ? 16'h0000 : 16'h0001;
      end
      if (rd_out && cyc == rd_start + RL - 1) m_datao = rd_val;
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin : compare
    logic [N*W-1:0] er;
    er = '0;
    er[W-1:0] = ID;
    if (!reset_n) begin
      check("rst_write_rdy", bus.di_write_rdy, 1);
      check("rst_read_rdy", bus.di_read_rdy, 0);
      check("rst_datao", bus.di_reg_datao, 0);
      check("rst_status", bus.di_transfer_status, 0);
      check("rst_stb", reg_wr_stb, 0);
      check("rst_wr_addr", reg_wr_addr, 0);
      check("rst_regs", regs_flat, er);
    end else begin
      for (int k = 1; k < N; k++) er[k*W +: W] = m_regs[k];
      check("write_rdy", bus.di_write_rdy, (cyc >= busy_end) && !(rd_out && cyc < rd_start + RL));
      check("read_rdy", bus.di_read_rdy, rd_out && (cyc >= rd_start + RL));
      check("datao", bus.di_reg_datao, m_datao);
      check("status", bus.di_transfer_status, m_status);
      check("wr_stb", reg_wr_stb, m_stb);
      check("wr_addr", reg_wr_addr, m_wr_addr);
      check("regs_flat", regs_flat, er);
    end
  end

  task automatic drive(input logic [15:0] term, input logic [31:0] addr, input logic wr,
                       input logic [31:0] dat, input logic rq, input logic rd);
    bus.di_term_addr = term;
    bus.di_reg_addr  = addr;
    bus.di_write     = wr;
    bus.di_reg_datai = dat;
    bus.di_read_req  = rq;
    bus.di_read      = rd;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle();
    drive(T, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.di_term_addr = 16'h0; bus.di_reg_addr = 32'h0; bus.di_write = 1'b0;
    bus.di_reg_datai = 32'h0; bus.di_read_req = 1'b0; bus.di_read = 1'b0;
    reset_n = 1'b0;
    @(negedge clk); @(negedge clk); #1;
    reset_n = 1'b1;

    // Write 0x1234 to register 3
    drive(T, 32'd3, 1'b1, 32'h0000_1234, 1'b0, 1'b0);
    check("lit_w3_stb", reg_wr_stb, 1);
    check("lit_w3_addr", reg_wr_addr, 3);
    check("lit_w3_reg", regs_flat[63:48], 16'h1234);
    check("lit_w3_status", bus.di_transfer_status, 0);
    check("lit_w3_busy", bus.di_write_rdy, 0);
    idle();
    check("lit_w3_stb_once", reg_wr_stb, 0);
    check("lit_w3_rdy_back", bus.di_write_rdy, 1);

    // Read register 3: ready exactly two cycles after the request
    drive(T, 32'd3, 1'b0, 32'd0, 1'b1, 1'b0);
    check("lit_r3_not_yet", bus.di_read_rdy, 0);
    idle();
    check("lit_r3_rdy", bus.di_read_rdy, 1);
    check("lit_r3_data", bus.di_reg_datao, 32'h0000_1234);
    drive(T, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    check("lit_r3_consumed", bus.di_read_rdy, 0);
    check("lit_r3_hold", bus.di_reg_datao, 32'h0000_1234);

    // ID register, read-only write, out-of-range accesses
    drive(T, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0);
    idle();
    check("lit_id", bus.di_reg_datao, 32'h0000_A55A);
    drive(T, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);
    drive(T, 32'd0, 1'b1, 32'h0000_BEEF, 1'b0, 1'b0);
    check("lit_w0_stb", reg_wr_stb, 0);
    check("lit_w0_status", bus.di_transfer_status, 16'h0002);
    idle();
    drive(T, 32'd9, 1'b1, 32'h0000_7777, 1'b0, 1'b0);
    check("lit_w9_stb", reg_wr_stb, 0);
    check("lit_w9_status", bus.di_transfer_status, 16'h0001);
    idle();
    drive(T, 32'd9, 1'b0, 32'd0, 1'b1, 1'b0);
    idle();
    check("lit_r9_rdy", bus.di_read_rdy, 1);
    check("lit_r9_data", bus.di_reg_datao, 32'd0);
    check("lit_r9_status", bus.di_transfer_status, 16'h0001);
    drive(T, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);

    // Write and read of register 5 in the same cycle, then a write while busy
    drive(T, 32'd5, 1'b1, 32'h0000_00FF, 1'b1, 1'b0);
    check("lit_w5_stb", reg_wr_stb, 1);
    check("lit_w5_addr", reg_wr_addr, 5);
    drive(T, 32'd5, 1'b1, 32'h0000_1111, 1'b0, 1'b0);
    check("lit_overrun", bus.di_transfer_status, 16'h0004);
    idle();
    check("lit_pend_wait", bus.di_read_rdy, 0);
    idle();
    check("lit_pend_rdy", bus.di_read_rdy, 1);
    check("lit_pend_data", bus.di_reg_datao, 32'h0000_00FF);
    check("lit_w5_kept", regs_flat[95:80], 16'h00FF);
    drive(T, 32'd0, 1'b0, 32'd0, 1'b0, 1'b1);

    // Foreign terminal address: nothing happens
    drive(16'h0011, 32'd4, 1'b1, 32'h0000_DEAD, 1'b1, 1'b0);
    check("lit_foreign_stb", reg_wr_stb, 0);
    check("lit_foreign_reg", regs_flat[79:64], 16'h0000);
    check("lit_foreign_status", bus.di_transfer_status, 0);
    idle();
    check("lit_foreign_nord", bus.di_read_rdy, 0);

    // Reset in the middle of a read
    drive(T, 32'd3, 1'b0, 32'd0, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    check("lit_rst_rdy", bus.di_read_rdy, 0);
    check("lit_rst_regs", regs_flat[127:16], 112'd0);
    idle();
    check("lit_rst_rdy_hold", bus.di_read_rdy, 0);
    reset_n = 1'b1;
    drive(T, 32'd2, 1'b1, 32'h0000_4242, 1'b0, 1'b0);
    check("lit_post_rst_stb", reg_wr_stb, 1);
    check("lit_post_rst_reg", regs_flat[47:32], 16'h4242);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [15:0] term;
      logic [31:0] a;
      term = ($urandom_range(0, 9) == 0) ? 16'h0011 : T;
      case ($urandom_range(0, 9))
        0:       a = 32'h0000_0103;
        1:       a = 32'h8000_0002;
        default: a = 32'($urandom_range(0, 9));
      endcase
      if ($urandom_range(0, 149) == 0) begin
        reset_n = 1'b0;
        idle();
        reset_n = 1'b1;
      end else begin
        drive(term, a, ($urandom_range(0, 9) < 3), $urandom,
              ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 4));
      end
    end
    idle();
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/di_reg_terminal.md
DI_REG_TERMINAL -- requirements
Module: di_reg_terminal

Interface
REQ-001 Parameters SHALL be:
- TERM_ADDR, default 16'h0010, terminal address this block answers to.
- NUM_REGS, default 8, register count (2..256).
- REG_WIDTH, default 16, register width (8..32).
- READ_LATENCY, default 2, cycles from read request to read-ready (1..15).
- WRITE_LATENCY, default 1, busy cycles after an accepted write (0..15).
- ID_VALUE, default 16'hA55A, value of read-only register 0.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  single clock.
- reset_n  in  1  reset; asynchronous, active-low.
- di_term_addr  in  16  terminal address of the current transfer.
- di_reg_addr  in  32  register address.
- di_write  in  1  one-cycle write strobe.
- di_reg_datai  in  32  write data; low REG_WIDTH bits are used.
- di_write_rdy  out  1  terminal can accept a write.
- di_read_req  in  1  one-cycle request to fetch di_reg_addr.
- di_read  in  1  one-cycle strobe consuming the presented word.
- di_read_rdy  out  1  di_reg_datao is valid.
- di_reg_datao  out  32  read data, zero-extended.
- di_transfer_status  out  16  status of the last access.
- regs_flat  out  NUM_REGS*REG_WIDTH  all register contents, reg k at bits [k*REG_WIDTH +: REG_WIDTH].
- reg_wr_stb  out  1  one-cycle pulse when a register is updated.
- reg_wr_addr  out  8  index of the updated register.

Function
REQ-003 The block SHALL be selected only when di_term_addr == TERM_ADDR; di_write, di_read_req and di_read SHALL be ignored when it is not selected.
REQ-004 The FSM SHALL have four states: IDLE, RD_WAIT, RD_VALID and WR_BUSY.
REQ-005 di_write_rdy SHALL be 1 in IDLE and RD_VALID and 0 in RD_WAIT and WR_BUSY.
REQ-006 A selected di_write with di_write_rdy=1 SHALL write the register in the next cycle, pulse reg_wr_stb with reg_wr_addr for one cycle, and set status to 0.
REQ-007 After an accepted write, the FSM SHALL go to WR_BUSY for WRITE_LATENCY cycles, then return to IDLE; with WRITE_LATENCY=0 it SHALL stay in IDLE.
REQ-008 A write to address 0 SHALL leave the registers unchanged, produce no strobe, and set status to 16'h0002 (read-only).
REQ-009 A write to address >= NUM_REGS SHALL leave the registers unchanged, produce no strobe, and set status to 16'h0001 (out of range).
REQ-010 A selected write while di_write_rdy=0 SHALL be dropped and set status to 16'h0004 (overrun).
REQ-011 A selected di_read_req in IDLE or RD_VALID SHALL capture the address and enter RD_WAIT, clearing di_read_rdy.
REQ-012 di_read_rdy SHALL rise exactly READ_LATENCY cycles after the di_read_req cycle; the FSM SHALL then be in RD_VALID with di_reg_datao holding the register value sampled at that edge.
REQ-013 A read of address 0 SHALL return ID_VALUE.
REQ-014 A read of address >= NUM_REGS SHALL return 0 and set status to 16'h0001; otherwise a read SHALL set status to 0.
REQ-015 A selected di_read in RD_VALID SHALL clear di_read_rdy next cycle and return the FSM to IDLE; di_reg_datao SHALL hold its value.
REQ-016 A di_read when not in RD_VALID SHALL be ignored.
REQ-017 If di_write and di_read_req are asserted in the same cycle, the write SHALL take priority and the read SHALL be latched as pending; the pending read SHALL start on the first cycle the FSM is in IDLE.
REQ-018 A read of the register being written in the same cycle SHALL return the new value.
REQ-019 Address comparison SHALL use the full 32-bit di_reg_addr, so addresses whose upper bits are set are out of range and do not wrap.
REQ-020 The latency counters SHALL be 4 bits wide and SHALL NOT wrap.

Reset
REQ-021 While reset_n=0, asynchronously:
- FSM in IDLE, pending read cleared.
- Registers 1..NUM_REGS-1 = 0.
- di_write_rdy=1, di_read_rdy=0.
- di_reg_datao=0, di_transfer_status=0.
- reg_wr_stb=0, reg_wr_addr=0.
REQ-022 Reset asserted mid-read or mid-busy SHALL abort the operation with no further strobes, and the block SHALL accept a new access on the first cycle after release.

Verification
REQ-023 Write 0x1234 to addr 3 at TERM_ADDR -> reg_wr_stb once with addr 3; regs_flat[63:48]=0x1234; status 0; di_write_rdy low for 1 cycle.
REQ-024 read_req addr 3 -> di_read_rdy high exactly 2 cycles later, datao=0x1234; di_read -> rdy low next cycle.
REQ-025 Read addr 0 -> 0xA55A; write addr 0 -> no strobe, status 2; write and read addr 9 -> status 1, read data 0.
REQ-026 Simultaneous write 0x00FF to addr 5 and read_req addr 5 -> write done, then read returns 0x00FF; a second write during WR_BUSY -> status 4.
REQ-027 Access with di_term_addr=0x0011 -> no state change.
REQ-028 Assert reset_n=0 during RD_WAIT -> di_read_rdy stays 0, all registers 0, and a write issued after release is accepted.
